// File: rtl/cpu_types_pkg.sv
// Shared types, view codes and the seven-segment encoder for the ALU exerciser.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } exer_state_t;

  localparam logic [1:0] VIEW_RES  = 2'd0;
  localparam logic [1:0] VIEW_A    = 2'd1;
  localparam logic [1:0] VIEW_B    = 2'd2;
  localparam logic [1:0] VIEW_STAT = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] hex7seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b0100111;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/alu_exerciser_key_debounce.sv
// One push-key: 2-flop synchroniser, stability down-counter and a press pulse
// on each debounced released-to-pressed transition.
module key_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_n;
  logic             deb_n;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_n <= 2'b11;
      deb_n  <= 1'b1;
      cnt    <= RELOAD;
      press  <= 1'b0;
    end else begin
      sync_n <= {sync_n[0], key_n};
      press  <= 1'b0;
      if (sync_n[1] != deb_n) begin
        // Terminal count reached on the DEB_CYCLES-th consecutive differing cycle.
        if (cnt == '0) begin
          deb_n <= sync_n[1];
          cnt   <= RELOAD;
          press <= ~sync_n[1];
        end else begin
          cnt <= cnt - 1'b1;
        end
      end else begin
        cnt <= RELOAD;
      end
    end
  end

  assign pressed = ~deb_n;

endmodule

// File: rtl/alu_exerciser.sv
// Board-level exerciser: loads operands from switches, sequences one external
// ALU operation per key press and shows registers on the seven-segment digits.
module alu_exerciser
  import cpu_types_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMM_W      = 16,
  parameter int OP_W       = 4,
  parameter int DEB_CYCLES = 50000,
  parameter int NDIGITS    = DATA_W / 4
) (
  input  logic                 CLOCK_50,
  input  logic                 nRST,
  input  logic [3:0]           key_n,
  input  logic [IMM_W-1:0]     sw_imm,
  input  logic                 sw_sext,
  input  logic [OP_W-1:0]      sw_op,
  input  logic [1:0]           sw_view,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [OP_W-1:0]      alu_op,
  input  logic [DATA_W-1:0]    alu_result,
  output logic [NDIGITS*7-1:0] hex,
  output logic [8:0]           ledg
);

  logic [3:0] key_level;
  logic [3:0] key_pulse;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (CLOCK_50),
      .rst_n   (nRST),
      .key_n   (key_n[k]),
      .pressed (key_level[k]),
      .press   (key_pulse[k])
    );
  end

  exer_state_t state, state_next;
  logic [DATA_W-1:0] a_reg, b_reg, res_reg;
  logic [OP_W-1:0]   op_reg;
  logic [7:0]        op_cnt;
  logic              res_valid, zero_flag, acc_pending;
  logic              load_a, load_b, start, start_acc, capture;
  logic [DATA_W-1:0] imm_ext;

  assign imm_ext = sw_sext ? DATA_W'($signed(sw_imm)) : DATA_W'(sw_imm);

  always_ff @(posedge CLOCK_50 or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  // Priority KEY0 > KEY1 > KEY2 > KEY3; losers and busy-time pulses are dropped.
  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    start      = 1'b0;
    start_acc  = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (key_pulse[0]) load_a = 1'b1;
        else if (key_pulse[1]) load_b = 1'b1;
        else if (key_pulse[2]) begin
          start      = 1'b1;
          state_next = ISSUE;
        end else if (key_pulse[3]) begin
          start      = 1'b1;
          start_acc  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = CAPTURE;
      CAPTURE: begin
        capture    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge nRST) begin
    if (!nRST) begin
      a_reg       <= '0;
      b_reg       <= '0;
      res_reg     <= '0;
      op_reg      <= '0;
      op_cnt      <= '0;
      res_valid   <= 1'b0;
      zero_flag   <= 1'b0;
      acc_pending <= 1'b0;
    end else begin
      if (load_a) begin
        a_reg     <= imm_ext;
        res_valid <= 1'b0;
      end
      if (load_b) begin
        b_reg     <= imm_ext;
        res_valid <= 1'b0;
      end
      if (start) begin
        op_reg      <= sw_op;
        acc_pending <= start_acc;
      end
      if (capture) begin
        res_reg     <= alu_result;
        zero_flag   <= (alu_result == '0);
        res_valid   <= 1'b1;
        op_cnt      <= op_cnt + 8'd1;
        acc_pending <= 1'b0;
        if (acc_pending) a_reg <= alu_result;
      end
    end
  end

  assign alu_a  = a_reg;
  assign alu_b  = b_reg;
  assign alu_op = op_reg;

  logic [3:0]           op_nib;
  logic [NDIGITS*7-1:0] hex_next;

  assign op_nib = 4'(op_reg);

  always_comb begin
    hex_next = '1;
    for (int i = 0; i < NDIGITS; i++) begin
      case (sw_view)
        VIEW_RES: hex_next[7*i +: 7] = res_valid ? hex7seg(res_reg[4*i +: 4]) : SEG_BLANK;
        VIEW_A:   hex_next[7*i +: 7] = hex7seg(a_reg[4*i +: 4]);
        VIEW_B:   hex_next[7*i +: 7] = hex7seg(b_reg[4*i +: 4]);
        default: begin
          if (i == 0)      hex_next[7*i +: 7] = hex7seg(op_cnt[3:0]);
          else if (i == 1) hex_next[7*i +: 7] = hex7seg(op_cnt[7:4]);
          else if (i == 2) hex_next[7*i +: 7] = hex7seg(op_nib);
          else             hex_next[7*i +: 7] = SEG_BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nRST) begin
    if (!nRST) hex <= '1;
    else       hex <= hex_next;
  end

  assign ledg = {acc_pending, res_reg[DATA_W-1], (state != IDLE), zero_flag, res_valid, key_level};

endmodule
